sha256_padder: RTL
==================

# sha256_padder

Message padder and block former sitting in front of the SHA-256 core. Accepts a message as a stream of big-endian 32-bit words. Applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit bit-length. Presents complete 512-bit blocks in the `[0:15][31:0]` layout the message scheduler's `data_in` expects, with a valid/ready handshake toward the core's block loader.

## Interface
Parameters: none.

- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  begin new message; honoured only in IDLE
- in_valid  in  1  message word valid
- in_ready  out  1  padder accepts a word this cycle (in_valid & in_ready = beat)
- in_data  in  32  message word; first byte in [31:24]
- in_last  in  1  beat is the final message word
- in_nbytes  in  3  valid bytes in a last beat, 0..4; ignored when in_last=0
- block  out  [0:15][31:0]  padded block; word 0 is scheduler `data_in[0]`
- block_valid  out  1  block holds a complete block
- block_ready  in  1  downstream takes the block (valid & ready = handoff)
- block_last  out  1  current block is the final block of the message
- busy  out  1  state != IDLE
- err  out  1  sticky protocol error (see Configuration)

## Operation
- States: IDLE, FILL, PAD, EMIT.
- Registers: word index `widx[3:0]`, 64-bit bit counter `len`, flag `mk`, flag `fin`.
  - `mk`: 0x80 marker already written.
  - `fin`: length already written.
- **IDLE**
  - `start` clears `len`, `widx`, `mk`, `fin` and the block buffer, then goes to FILL.
- **FILL**
  - `in_ready` = 1.
  - Non-last beat:
    - `block[widx] <= in_data`; `len += 32`.
    - If `widx` = 15, go to EMIT; otherwise `widx++`.
  - Last beat with n = in_nbytes:
    - `len += 8n`.
    - If n < 4: write the word with bytes ≥ n zeroed and byte n = 0x80; set `mk`.
    - If n = 4: write `in_data` unchanged; `mk` stays 0.
    - Go to PAD, or to EMIT if `widx` was 15. `widx` advances (15 wraps to 0).
- **PAD** writes one word per cycle at `widx`:
  - If `mk`=1, `widx`=14: write `len[63:32]`.
  - If `mk`=1, `widx`=15, length-high already written: write `len[31:0]`; set `fin`.
  - Otherwise, if `mk`=0: write 0x80000000 and set `mk`.
  - Otherwise: write 0.
  - After writing word 15, go to EMIT; otherwise `widx++`.
- **EMIT**
  - `block_valid`=1; `block_last`=`fin`. The block is held stable.
  - On handoff:
    - If `fin`, go to IDLE.
    - Else if the message is ended, go to PAD with `widx`=0 and the buffer zeroed.
    - Else go to FILL with `widx`=0.
- Length rule: the length goes in words 14/15 only when the marker precedes them in the same block. Otherwise a second block is emitted.
- Width: `len` wraps modulo 2^64, with no saturation.
- in_nbytes > 4 on a last beat is treated as 4.
- `start` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE
  - in_ready, block_valid, block_last, busy, err = 0
  - block = all zeros
  - `len`, `widx`, `mk`, `fin` = 0
- One beat per cycle max in FILL. 16 back-to-back beats give block_valid on the cycle after the 16th beat.
- PAD: block_valid rises the cycle after the cycle that writes word 15.
  - Example: last beat at word 0 in cycle 0 → words 1..15 in cycles 1..15 → block_valid in cycle 16.
- block_valid stays high until handoff; it drops the cycle after handoff unless the next block is already complete (it never is, minimum 1 cycle gap).
- in_ready is 0 in IDLE, PAD, EMIT. No input is accepted while a block is pending.
- Reset mid-message aborts immediately. No partial block is emitted.

## Configuration
- `SHA256_PADDER_CHECK_EN` defined:
  - `err` is set sticky on any of: a last beat with in_nbytes > 4; a non-last beat while in_valid with in_nbytes ≠ 4; `start` asserted while busy.
  - `err` is cleared only by reset.
  - Data path behaviour is unchanged.
- Not defined: `err` tied 0 and no checking logic is built.

## Test plan
- "abc": start; beat 0x61626300, last, n=3 → one block; word0 0x61626380, words 1–14 0, word15 0x00000018, block_last=1; block_valid at cycle 16 after beat.
- Empty message: beat last, n=0 → word0 0x80000000, all else 0, block_last=1.
- 14 full words, last n=4 → block 1: word14 0x80000000, word15 0, block_last=0; block 2: words 0–14 zero, word15 0x000001C0, block_last=1.
- 16 full words, last n=4 on word 15 → block 1 = data, block_last=0; block 2: word0 0x80000000, word15 0x00000200, block_last=1.
- Backpressure: hold block_ready low 5 cycles in EMIT → block bits stable, in_ready=0, then one handoff only.
- Reset asserted in PAD → all outputs at reset values next edge; new `start` + "abc" yields the correct block. With the macro defined: `start` during busy → err=1 and held.

Source files
------------

// File: rtl/sha256_padder_if.sv
// sha256_padder_if: message-in / block-out bundle for the SHA-256 padder.
//   master: upstream message source and downstream block loader (drives start, in_*, block_ready)
//   slave : the padder (drives in_ready, block, block_valid, block_last, busy, err)
//   start        begin a new message (honoured only when idle)
//   in_valid     message word valid; in_ready accepts it (valid & ready = beat)
//   in_data      big-endian message word, first byte in [31:24]
//   in_last      beat is the final message word; in_nbytes = valid bytes (0..4)
//   block        padded 512-bit block, word 0 = scheduler data_in[0]
//   block_valid  block complete; block_ready takes it (valid & ready = handoff)
//   block_last   current block is the final block of the message
//   busy, err    not idle; sticky protocol error
interface sha256_padder_if;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_last;
  logic [2:0]        in_nbytes;
  logic [0:15][31:0] block;
  logic              block_valid;
  logic              block_ready;
  logic              block_last;
  logic              busy;
  logic              err;

  modport master (
    output start, in_valid, in_data, in_last, in_nbytes, block_ready,
    input  in_ready, block, block_valid, block_last, busy, err
  );

  modport slave (
    input  start, in_valid, in_data, in_last, in_nbytes, block_ready,
    output in_ready, block, block_valid, block_last, busy, err
  );
endinterface

// File: rtl/sha256_padder.sv
// sha256_padder: FIPS 180-4 message padder and block former for the SHA-256 core.
// Takes big-endian 32-bit message words, appends the 0x80 marker, zero fill and the 64-bit
// bit length, and presents 512-bit blocks with a valid/ready handshake.
// Ports:
//   clk    rising-edge clock
//   n_rst  asynchronous active-low reset
//   bus    sha256_padder_if.slave (message input, block output, busy, err)
// Optional feature: define SHA256_PADDER_CHECK_EN to build the sticky protocol checker
// driving err; otherwise err is tied low.
module sha256_padder (
  input  logic           clk,
  input  logic           n_rst,
  sha256_padder_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFill = 2'd1;
  localparam logic [1:0] StPad  = 2'd2;
  localparam logic [1:0] StEmit = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [3:0]        widx_q, widx_d;
  logic [63:0]       len_q, len_d;
  logic              mk_q, mk_d;    // marker written
  logic              fin_q, fin_d;  // length low word written
  logic              hi_q, hi_d;    // length high word written in the current block
  logic              eom_q, eom_d;  // last message beat already taken
  logic [0:15][31:0] blk_q, blk_d;

  logic        beat;
  logic        handoff;
  logic        busy;
  logic [2:0]  nb;
  logic [31:0] last_word;

  assign beat    = bus.in_valid & (state_q == StFill);
  assign handoff = bus.block_ready & (state_q == StEmit);
  assign busy    = (state_q != StIdle);

  // Byte count of a last beat, with out-of-range values treated as a full word.
  assign nb = (bus.in_nbytes > 3'd4) ? 3'd4 : bus.in_nbytes;

  // Last word: keep the valid bytes, put the marker right after them.
  always_comb begin
    last_word = bus.in_data;
    case (nb)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {bus.in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {bus.in_data[31:16], 16'h8000};
      3'd3:    last_word = {bus.in_data[31:8], 8'h80};
      default: last_word = bus.in_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    len_d   = len_q;
    mk_d    = mk_q;
    fin_d   = fin_q;
    hi_d    = hi_q;
    eom_d   = eom_q;
    blk_d   = blk_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          widx_d  = 4'd0;
          len_d   = 64'd0;
          mk_d    = 1'b0;
          fin_d   = 1'b0;
          hi_d    = 1'b0;
          eom_d   = 1'b0;
          blk_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (beat) begin
          widx_d = widx_q + 4'd1;
          if (!bus.in_last) begin
            blk_d[widx_q] = bus.in_data;
            len_d         = len_q + 64'd32;
            if (widx_q == 4'd15) state_d = StEmit;
          end else begin
            blk_d[widx_q] = last_word;
            len_d         = len_q + {58'd0, nb, 3'b000};
            mk_d          = (nb != 3'd4);
            eom_d         = 1'b1;
            state_d       = (widx_q == 4'd15) ? StEmit : StPad;
          end
        end
      end
      StPad: begin
        // Length only lands in 14/15 when the marker is already behind us.
        if (mk_q && widx_q == 4'd14) begin
          blk_d[widx_q] = len_q[63:32];
          hi_d          = 1'b1;
        end else if (mk_q && widx_q == 4'd15 && hi_q) begin
          blk_d[widx_q] = len_q[31:0];
          fin_d         = 1'b1;
        end else if (!mk_q) begin
          blk_d[widx_q] = 32'h8000_0000;
          mk_d          = 1'b1;
        end else begin
          blk_d[widx_q] = 32'h0;
        end
        widx_d = widx_q + 4'd1;
        if (widx_q == 4'd15) state_d = StEmit;
      end
      StEmit: begin
        if (handoff) begin
          widx_d = 4'd0;
          if (fin_q) begin
            state_d = StIdle;
          end else if (eom_q) begin
            blk_d   = '0;
            hi_d    = 1'b0;
            state_d = StPad;
          end else begin
            state_d = StFill;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      widx_q  <= 4'd0;
      len_q   <= 64'd0;
      mk_q    <= 1'b0;
      fin_q   <= 1'b0;
      hi_q    <= 1'b0;
      eom_q   <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      len_q   <= len_d;
      mk_q    <= mk_d;
      fin_q   <= fin_d;
      hi_q    <= hi_d;
      eom_q   <= eom_d;
      blk_q   <= blk_d;
    end
  end

  assign bus.in_ready    = (state_q == StFill);
  assign bus.block       = blk_q;
  assign bus.block_valid = (state_q == StEmit);
  assign bus.block_last  = (state_q == StEmit) & fin_q;
  assign bus.busy        = busy;

`ifdef SHA256_PADDER_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_q <= 1'b0;
    end else if ((beat && bus.in_last && bus.in_nbytes > 3'd4) ||
                 (beat && !bus.in_last && bus.in_nbytes != 3'd4) ||
                 (bus.start && busy)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
